// File: rtl/i3c_bus_phy_ctrl_pkg.sv
// Shared I3C PHY definitions: command encodings, FSM states and the default
// phase-count width.
package i3c_params;

  localparam int CNT_W_DEF = 8;

  localparam logic [2:0] CMD_START  = 3'd0;
  localparam logic [2:0] CMD_RSTART = 3'd1;
  localparam logic [2:0] CMD_WR     = 3'd2;
  localparam logic [2:0] CMD_RD     = 3'd3;
  localparam logic [2:0] CMD_STOP   = 3'd4;

  typedef enum logic [3:0] {
    IDLE,
    START_HD,
    RS_LO,
    RS_HI,
    RS_HD,
    BIT_LO,
    BIT_HI,
    STOP_LO,
    STOP_HI,
    HOLD
  } state_e;

  // Phases where a target may stretch SCL by holding it low.
  function automatic logic is_high_phase(state_e s);
    return (s == RS_HI) || (s == BIT_HI) || (s == STOP_HI);
  endfunction

endpackage

// File: rtl/i3c_bus_phy_ctrl_if.sv
// Bundle of the PHY command handshake, phase counts and bus lines.
// master = the side issuing commands, slave = the PHY controller.
interface i3c_bus_phy_ctrl_if
  import i3c_params::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [2:0]       cmd_i;
  logic             cmd_pp_i;
  logic             wr_bit_i;
  logic [CNT_W-1:0] od_lo_i;
  logic [CNT_W-1:0] od_hi_i;
  logic [CNT_W-1:0] pp_lo_i;
  logic [CNT_W-1:0] pp_hi_i;
  logic             scl_i;
  logic             sda_i;
  logic             scl_o;
  logic             sda_o;
  logic             sel_od_pp_o;
  logic             rd_data_o;
  logic             rd_valid_o;
  logic             busy_o;
  logic             err_o;

  modport master (
    output cmd_valid_i, cmd_i, cmd_pp_i, wr_bit_i,
           od_lo_i, od_hi_i, pp_lo_i, pp_hi_i, scl_i, sda_i,
    input  cmd_ready_o, scl_o, sda_o, sel_od_pp_o,
           rd_data_o, rd_valid_o, busy_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_i, cmd_pp_i, wr_bit_i,
           od_lo_i, od_hi_i, pp_lo_i, pp_hi_i, scl_i, sda_i,
    output cmd_ready_o, scl_o, sda_o, sel_od_pp_o,
           rd_data_o, rd_valid_o, busy_o, err_o
  );
endinterface

// File: rtl/i3c_bus_phy_ctrl_phase_cnt.sv
// SCL phase timer: loaded with (length - 1), counts down, flags the last cycle.
// A stretch request freezes the count and suppresses the done flag.
module i3c_phase_cnt
  import i3c_params::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             stretch_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!stretch_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0) && !stretch_i;

endmodule

// File: rtl/i3c_bus_phy_ctrl.sv
// I3C bus PHY controller: sequences START/RSTART/WR/RD/STOP on SCL/SDA.
// Define I3C_CLK_STRETCH_EN to let a low scl_i extend the SCL high phases.
module i3c_bus_phy_ctrl
  import i3c_params::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_i,
  input  logic             cmd_pp_i,
  input  logic             wr_bit_i,
  input  logic [CNT_W-1:0] od_lo_i,
  input  logic [CNT_W-1:0] od_hi_i,
  input  logic [CNT_W-1:0] pp_lo_i,
  input  logic [CNT_W-1:0] pp_hi_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_o,
  output logic             sda_o,
  output logic             sel_od_pp_o,
  output logic             rd_data_o,
  output logic             rd_valid_o,
  output logic             busy_o,
  output logic             err_o
);

  state_e           state_q, state_d;
  logic             scl_q, scl_d, sda_q, sda_d;
  logic             ready_q, ready_d, err_q, err_d;
  logic             rd_data_q, rd_data_d;
  logic             pp_q, pp_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] od_hi_q, od_hi_d, bit_hi_q, bit_hi_d;
  logic             accept, ld, done, stretch, rd_valid;
  logic [CNT_W-1:0] ld_val;

  assign accept = cmd_valid_i && ready_q;

`ifdef I3C_CLK_STRETCH_EN
  assign stretch = is_high_phase(state_q) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stretch    = 1'b0;
`endif

  i3c_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ld),
    .load_val_i (ld_val),
    .stretch_i  (stretch),
    .done_o     (done)
  );

  // The first phase is loaded straight from the inputs on the accept edge;
  // later phases use the copies captured at that same edge.
  always_comb begin
    state_d  = state_q;
    scl_d    = scl_q;
    sda_d    = sda_q;
    err_d    = 1'b0;
    pp_d     = pp_q;
    cmd_d    = cmd_q;
    od_hi_d  = od_hi_q;
    bit_hi_d = bit_hi_q;
    ld       = 1'b0;
    ld_val   = '0;
    if (accept) begin
      cmd_d    = cmd_i;
      pp_d     = cmd_pp_i;
      od_hi_d  = od_hi_i;
      bit_hi_d = cmd_pp_i ? pp_hi_i : od_hi_i;
    end
    unique case (state_q)
      IDLE: if (accept) begin
        if (cmd_i == CMD_START) begin
          state_d = START_HD; sda_d = 1'b0; ld = 1'b1; ld_val = od_hi_i;
        end else begin
          err_d = 1'b1;
        end
      end
      HOLD: if (accept) begin
        unique case (cmd_i)
          CMD_RSTART: begin
            state_d = RS_LO; sda_d = 1'b1; ld = 1'b1; ld_val = od_lo_i;
          end
          CMD_WR, CMD_RD: begin
            state_d = BIT_LO; ld = 1'b1;
            sda_d   = (cmd_i == CMD_WR) ? wr_bit_i : 1'b1;
            ld_val  = cmd_pp_i ? pp_lo_i : od_lo_i;
          end
          CMD_STOP: begin
            state_d = STOP_LO; sda_d = 1'b0; ld = 1'b1; ld_val = od_lo_i;
          end
          default: err_d = 1'b1;
        endcase
      end
      START_HD: if (done) begin state_d = HOLD; scl_d = 1'b0; end
      RS_LO: if (done) begin
        state_d = RS_HI; scl_d = 1'b1; ld = 1'b1; ld_val = od_hi_q;
      end
      RS_HI: if (done) begin
        state_d = RS_HD; sda_d = 1'b0; ld = 1'b1; ld_val = od_hi_q;
      end
      RS_HD: if (done) begin state_d = HOLD; scl_d = 1'b0; end
      BIT_LO: if (done) begin
        state_d = BIT_HI; scl_d = 1'b1; ld = 1'b1; ld_val = bit_hi_q;
      end
      BIT_HI: if (done) begin state_d = HOLD; scl_d = 1'b0; end
      STOP_LO: if (done) begin
        state_d = STOP_HI; scl_d = 1'b1; ld = 1'b1; ld_val = od_hi_q;
      end
      STOP_HI: if (done) begin state_d = IDLE; sda_d = 1'b1; end
      default: ;
    endcase
    ready_d = (state_d == IDLE) || (state_d == HOLD);
  end

  assign rd_valid  = (state_q == BIT_HI) && done && (cmd_q == CMD_RD);
  assign rd_data_d = rd_valid ? sda_i : rd_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 1'b0;
      pp_q      <= 1'b0;
      cmd_q     <= CMD_START;
      od_hi_q   <= '0;
      bit_hi_q  <= '0;
    end else begin
      state_q   <= state_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      pp_q      <= pp_d;
      cmd_q     <= cmd_d;
      od_hi_q   <= od_hi_d;
      bit_hi_q  <= bit_hi_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign scl_o       = scl_q;
  assign sda_o       = sda_q;
  assign sel_od_pp_o = pp_q && ((state_q == BIT_LO) || (state_q == BIT_HI));
  assign rd_valid_o  = rd_valid;
  assign rd_data_o   = rd_data_d;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_i3c_bus_phy_ctrl.sv
// Directed bench for i3c_bus_phy_ctrl: bus sequences, illegal commands,
// asynchronous reset, clock stretching and zero-length phases.
module tb_i3c_bus_phy_ctrl;
  import i3c_params::*;

  logic clk = 1'b0;
  logic rst_ni;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  i3c_bus_phy_ctrl_if #(.CNT_W(8)) bus ();

  i3c_bus_phy_ctrl #(.CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (bus.cmd_valid_i),
    .cmd_ready_o (bus.cmd_ready_o),
    .cmd_i       (bus.cmd_i),
    .cmd_pp_i    (bus.cmd_pp_i),
    .wr_bit_i    (bus.wr_bit_i),
    .od_lo_i     (bus.od_lo_i),
    .od_hi_i     (bus.od_hi_i),
    .pp_lo_i     (bus.pp_lo_i),
    .pp_hi_i     (bus.pp_hi_i),
    .scl_i       (bus.scl_i),
    .sda_i       (bus.sda_i),
    .scl_o       (bus.scl_o),
    .sda_o       (bus.sda_o),
    .sel_od_pp_o (bus.sel_od_pp_o),
    .rd_data_o   (bus.rd_data_o),
    .rd_valid_o  (bus.rd_valid_o),
    .busy_o      (bus.busy_o),
    .err_o       (bus.err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk($sformatf("%s_scl", tag),   32'(bus.scl_o),       32'd1);
    chk($sformatf("%s_sda", tag),   32'(bus.sda_o),       32'd1);
    chk($sformatf("%s_sel", tag),   32'(bus.sel_od_pp_o), 32'd0);
    chk($sformatf("%s_rdy", tag),   32'(bus.cmd_ready_o), 32'd0);
    chk($sformatf("%s_rdat", tag),  32'(bus.rd_data_o),   32'd0);
    chk($sformatf("%s_rvld", tag),  32'(bus.rd_valid_o),  32'd0);
    chk($sformatf("%s_busy", tag),  32'(bus.busy_o),      32'd0);
    chk($sformatf("%s_err", tag),   32'(bus.err_o),       32'd0);
  endtask

  task automatic expect_cyc(input string tag, input int n,
                            input logic e_scl, input logic e_sda, input logic e_sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_scl", tag),  32'(bus.scl_o),       32'(e_scl));
      chk($sformatf("%s_sda", tag),  32'(bus.sda_o),       32'(e_sda));
      chk($sformatf("%s_sel", tag),  32'(bus.sel_od_pp_o), 32'(e_sel));
      chk($sformatf("%s_busy", tag), 32'(bus.busy_o),      32'd1);
    end
  endtask

  task automatic send(input logic [2:0] c, input logic pp, input logic wb);
    chk("cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_i       = c;
    bus.cmd_pp_i    = pp;
    bus.wr_bit_i    = wb;
    bus.cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic set_counts(input logic [7:0] ol, input logic [7:0] oh,
                            input logic [7:0] pl, input logic [7:0] ph);
    bus.od_lo_i = ol; bus.od_hi_i = oh; bus.pp_lo_i = pl; bus.pp_hi_i = ph;
  endtask

  task automatic read_bit(input string tag, input logic bit_val);
    bus.sda_i = bit_val;
    send(CMD_RD, 1'b0, 1'b0);
    expect_cyc($sformatf("%s_lo", tag), 4, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s_hi_scl", tag), 32'(bus.scl_o), 32'd1);
      chk($sformatf("%s_rvld%0d", tag, k), 32'(bus.rd_valid_o), 32'(k == 3));
      if (k == 3) chk($sformatf("%s_rdat", tag), 32'(bus.rd_data_o), 32'(bit_val));
    end
    @(negedge clk);
    chk($sformatf("%s_hold_rvld", tag), 32'(bus.rd_valid_o), 32'd0);
    chk($sformatf("%s_hold_rdat", tag), 32'(bus.rd_data_o),  32'(bit_val));
    chk($sformatf("%s_hold_scl", tag),  32'(bus.scl_o),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   hi_len;
    int   exp_hi;
    rst_ni          = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i       = CMD_START;
    bus.cmd_pp_i    = 1'b0;
    bus.wr_bit_i    = 1'b0;
    bus.scl_i       = 1'b1;
    bus.sda_i       = 1'b1;
    set_counts(8'd4, 8'd4, 8'd2, 8'd2);

    // Reset state and first ready edge
    repeat (2) @(negedge clk);
    check_reset("por");
    rst_ni = 1'b1;
    @(negedge clk);
    chk("por_rdy_rise", 32'(bus.cmd_ready_o), 32'd1);
    chk("por_idle_busy", 32'(bus.busy_o), 32'd0);

    // START, push-pull WR 1, STOP
    send(CMD_START, 1'b0, 1'b0);
    expect_cyc("st_hd", 5, 1'b1, 1'b0, 1'b0);
    expect_cyc("st_hold", 1, 1'b0, 1'b0, 1'b0);
    send(CMD_WR, 1'b1, 1'b1);
    bus.pp_hi_i = 8'd7;
    expect_cyc("wr_lo", 3, 1'b0, 1'b1, 1'b1);
    expect_cyc("wr_hi", 3, 1'b1, 1'b1, 1'b1);
    expect_cyc("wr_hold", 1, 1'b0, 1'b1, 1'b0);
    bus.pp_hi_i = 8'd2;
    send(CMD_STOP, 1'b0, 1'b0);
    expect_cyc("sp_lo", 5, 1'b0, 1'b0, 1'b0);
    expect_cyc("sp_hi", 5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("sp_idle_scl",  32'(bus.scl_o),       32'd1);
    chk("sp_idle_sda",  32'(bus.sda_o),       32'd1);
    chk("sp_idle_busy", 32'(bus.busy_o),      32'd0);
    chk("sp_idle_rdy",  32'(bus.cmd_ready_o), 32'd1);

    // WR while idle is illegal
    send(CMD_WR, 1'b0, 1'b0);
    @(negedge clk);
    chk("ill_idle_err",  32'(bus.err_o),  32'd1);
    chk("ill_idle_scl",  32'(bus.scl_o),  32'd1);
    chk("ill_idle_sda",  32'(bus.sda_o),  32'd1);
    chk("ill_idle_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    chk("ill_idle_err_end", 32'(bus.err_o), 32'd0);

    // START, illegal START in HOLD, RSTART, two reads
    set_counts(8'd3, 8'd3, 8'd2, 8'd2);
    send(CMD_START, 1'b0, 1'b0);
    expect_cyc("st2_hd", 4, 1'b1, 1'b0, 1'b0);
    expect_cyc("st2_hold", 1, 1'b0, 1'b0, 1'b0);
    send(CMD_START, 1'b0, 1'b0);
    @(negedge clk);
    chk("ill_hold_err",  32'(bus.err_o),  32'd1);
    chk("ill_hold_scl",  32'(bus.scl_o),  32'd0);
    chk("ill_hold_busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    chk("ill_hold_err_end", 32'(bus.err_o), 32'd0);
    send(CMD_RSTART, 1'b0, 1'b0);
    expect_cyc("rs_lo", 4, 1'b0, 1'b1, 1'b0);
    expect_cyc("rs_hi", 4, 1'b1, 1'b1, 1'b0);
    expect_cyc("rs_hd", 4, 1'b1, 1'b0, 1'b0);
    expect_cyc("rs_hold", 1, 1'b0, 1'b0, 1'b0);
    read_bit("rd1", 1'b1);
    read_bit("rd0", 1'b0);
    bus.sda_i = 1'b1;

    // Asynchronous reset in the second BIT_HI cycle
    send(CMD_WR, 1'b0, 1'b1);
    expect_cyc("rw_lo", 4, 1'b0, 1'b1, 1'b0);
    expect_cyc("rw_hi", 2, 1'b1, 1'b1, 1'b0);
    #1 rst_ni = 1'b0;
    #1 check_reset("arst");
    @(negedge clk);
    rst_ni = 1'b1;
    #1 chk("arst_rdy_low", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk);
    chk("arst_rdy_rise", 32'(bus.cmd_ready_o), 32'd1);
    chk("arst_busy",     32'(bus.busy_o),      32'd0);

    // Clock stretch in BIT_HI: scl_i low for 10 cycles
    send(CMD_START, 1'b0, 1'b0);
    expect_cyc("st3_hd", 4, 1'b1, 1'b0, 1'b0);
    expect_cyc("st3_hold", 1, 1'b0, 1'b0, 1'b0);
    send(CMD_WR, 1'b0, 1'b1);
    expect_cyc("sw_lo", 4, 1'b0, 1'b1, 1'b0);
    bus.scl_i = 1'b0;
    hi_len = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.scl_o) break;
      hi_len++;
      if (hi_len == 11) bus.scl_i = 1'b1;
    end
    bus.scl_i = 1'b1;
`ifdef I3C_CLK_STRETCH_EN
    exp_hi = 14;
`else
    exp_hi = 4;
`endif
    chk("stretch_hi_len", 32'(hi_len), 32'(exp_hi));
    chk("stretch_hold_sda", 32'(bus.sda_o), 32'd1);
    send(CMD_STOP, 1'b0, 1'b0);
    expect_cyc("sp3_lo", 4, 1'b0, 1'b0, 1'b0);
    expect_cyc("sp3_hi", 4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("sp3_idle_busy", 32'(bus.busy_o), 32'd0);

    // All counts zero: single-cycle phases, back-to-back WR bits
    set_counts(8'd0, 8'd0, 8'd0, 8'd0);
    send(CMD_START, 1'b0, 1'b0);
    expect_cyc("z_st", 1, 1'b1, 1'b0, 1'b0);
    bus.cmd_i       = CMD_WR;
    bus.cmd_pp_i    = 1'b0;
    bus.wr_bit_i    = 1'b0;
    bus.cmd_valid_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("z_scl%0d", k), 32'(bus.scl_o),       32'((k % 3) == 2));
      chk($sformatf("z_rdy%0d", k), 32'(bus.cmd_ready_o), 32'((k % 3) == 0));
      chk($sformatf("z_sda%0d", k), 32'(bus.sda_o),       32'd0);
    end
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("z_hold_scl", 32'(bus.scl_o), 32'd0);
    send(3'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk("z_ill_err", 32'(bus.err_o), 32'd1);
    chk("z_ill_scl", 32'(bus.scl_o), 32'd0);
    send(CMD_STOP, 1'b0, 1'b0);
    expect_cyc("z_sp_lo", 1, 1'b0, 1'b0, 1'b0);
    expect_cyc("z_sp_hi", 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("z_idle_sda",  32'(bus.sda_o),  32'd1);
    chk("z_idle_busy", 32'(bus.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
